// File: rtl/ex_stage_pkg.sv
// ex_stage shared definitions: opcodes, function codes, divider states.
// Consumers import ex_stage_pkg::*.
package ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_ADDIU    = 6'h09;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  function automatic logic [DATA_W-1:0] neg32(
    input logic [DATA_W-1:0] v
  );
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// div_iter: 32-step restoring unsigned divider.
// o_done is high in the cycle whose closing edge performs the last step.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_quot,
  output logic [DATA_W-1:0] o_rem
);

  div_state_e        r_state;
  div_state_e        w_state_nxt;
  logic [4:0]        r_cnt;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dvs;

  logic [DATA_W:0]   w_shift;
  logic [DATA_W-1:0] w_sub;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quot_nxt;

  // Partial remainder stays below divisor, so the 32-bit difference is exact.
  always_comb begin
    w_shift    = {r_rem, r_quot[DATA_W-1]};
    w_ge       = w_shift >= {1'b0, r_dvs};
    w_sub      = w_shift[DATA_W-1:0] - r_dvs;
    w_rem_nxt  = w_ge ? w_sub : w_shift[DATA_W-1:0];
    w_quot_nxt = {r_quot[DATA_W-2:0], w_ge};
  end

  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    unique case (r_state)
      DIV_IDLE: begin
        if (i_start && !i_abort)
          w_state_nxt = DIV_BUSY;
      end
      DIV_BUSY: begin
        if (i_abort) begin
          w_state_nxt = DIV_IDLE;
        end else if (r_cnt == 5'd31) begin
          w_state_nxt = DIV_IDLE;
          o_done      = 1'b1;
        end
      end
      default: w_state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == DIV_IDLE) begin
        if (i_start && !i_abort) begin
          r_quot <= i_dividend;
          r_rem  <= '0;
          r_dvs  <= i_divisor;
          r_cnt  <= '0;
        end
      end else if (!i_abort) begin
        r_quot <= w_quot_nxt;
        r_rem  <= w_rem_nxt;
        r_cnt  <= r_cnt + 5'd1;
      end
    end
  end

  assign o_busy = (r_state == DIV_BUSY);
  assign o_quot = w_quot_nxt;
  assign o_rem  = w_rem_nxt;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage, HI/LO owner and EX/MEM latch.
// Define EX_SIGNED_DIV_EN to also decode signed DIV.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic [DATA_W-1:0]     operand_1,
  input  logic [DATA_W-1:0]     operand_2,
  input  logic [REG_ADDR_W-1:0] id_wreg_addr,
  input  logic                  id_wreg_en,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_result,
  output logic [REG_ADDR_W-1:0] ex_wreg_addr,
  output logic                  ex_wreg_en,
  output logic [DATA_W-1:0]     hi_out,
  output logic [DATA_W-1:0]     lo_out
);

  logic                  r_valid;
  logic [DATA_W-1:0]     r_result;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic                  r_wen;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic                  r_q_neg;
  logic                  r_r_neg;

  logic                  w_sp;
  logic [DATA_W-1:0]     w_res;
  logic                  w_wen;
  logic                  w_mult;
  logic                  w_div;
  logic                  w_sgn;
  logic                  w_div0;
  logic                  w_accept;
  logic                  w_start;
  logic [2*DATA_W-1:0]   w_prod;
  logic [DATA_W-1:0]     w_dvd_mag;
  logic [DATA_W-1:0]     w_dvs_mag;
  logic                  w_busy;
  logic                  w_done;
  logic [DATA_W-1:0]     w_quot;
  logic [DATA_W-1:0]     w_rem;
  logic [DATA_W-1:0]     w_quot_fix;
  logic [DATA_W-1:0]     w_rem_fix;

  assign w_sp = (op == OP_SPECIAL);

  always_comb begin
    w_res  = '0;
    w_wen  = 1'b0;
    w_mult = 1'b0;
    w_div  = 1'b0;
    w_sgn  = 1'b0;
    unique case (1'b1)
      (op == OP_ADDIU): begin
        w_res = operand_1 + operand_2;
        w_wen = id_wreg_en;
      end
      (w_sp && funct == FUNCT_ADDU): begin
        w_res = operand_1 + operand_2;
        w_wen = id_wreg_en;
      end
      (w_sp && funct == FUNCT_SUBU): begin
        w_res = operand_1 - operand_2;
        w_wen = id_wreg_en;
      end
      (w_sp && funct == FUNCT_AND): begin
        w_res = operand_1 & operand_2;
        w_wen = id_wreg_en;
      end
      (w_sp && funct == FUNCT_OR): begin
        w_res = operand_1 | operand_2;
        w_wen = id_wreg_en;
      end
      (w_sp && funct == FUNCT_XOR): begin
        w_res = operand_1 ^ operand_2;
        w_wen = id_wreg_en;
      end
      (w_sp && funct == FUNCT_SLT): begin
        w_res = {31'd0, $signed(operand_1) < $signed(operand_2)};
        w_wen = id_wreg_en;
      end
      (w_sp && funct == FUNCT_SLTU): begin
        w_res = {31'd0, operand_1 < operand_2};
        w_wen = id_wreg_en;
      end
      (w_sp && funct == FUNCT_MFHI): begin
        w_res = r_hi;
        w_wen = id_wreg_en;
      end
      (w_sp && funct == FUNCT_MFLO): begin
        w_res = r_lo;
        w_wen = id_wreg_en;
      end
      (w_sp && funct == FUNCT_MULTU): w_mult = 1'b1;
      (w_sp && funct == FUNCT_DIVU):  w_div  = 1'b1;
`ifdef EX_SIGNED_DIV_EN
      (w_sp && funct == FUNCT_DIV): begin
        w_div = 1'b1;
        w_sgn = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign w_prod   = operand_1 * operand_2;
  assign w_div0   = (operand_2 == '0);
  assign id_ready = rst_n & ~w_busy;
  assign w_accept = id_valid & id_ready & ~flush;
  assign w_start  = w_accept & w_div & ~w_div0;

  // Signed divide reuses the unsigned engine on magnitudes.
  assign w_dvd_mag = (w_sgn && operand_1[DATA_W-1]) ?
                     neg32(operand_1) : operand_1;
  assign w_dvs_mag = (w_sgn && operand_2[DATA_W-1]) ?
                     neg32(operand_2) : operand_2;

  div_iter u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_abort    (flush),
    .i_dividend (w_dvd_mag),
    .i_divisor  (w_dvs_mag),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_quot_fix = r_q_neg ? neg32(w_quot) : w_quot;
  assign w_rem_fix  = r_r_neg ? neg32(w_rem)  : w_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_waddr  <= '0;
      r_wen    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
    end else if (flush) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_waddr  <= '0;
      r_wen    <= 1'b0;
    end else if (w_done) begin
      r_valid  <= 1'b1;
      r_result <= '0;
      r_waddr  <= '0;
      r_wen    <= 1'b0;
      r_lo     <= w_quot_fix;
      r_hi     <= w_rem_fix;
    end else if (w_accept) begin
      r_valid  <= ~w_start;
      r_result <= w_res;
      r_waddr  <= id_wreg_addr;
      r_wen    <= w_wen;
      if (w_mult) begin
        r_hi <= w_prod[2*DATA_W-1:DATA_W];
        r_lo <= w_prod[DATA_W-1:0];
      end
      if (w_div && w_div0) begin
        r_lo <= '1;
        r_hi <= operand_1;
      end
      if (w_start) begin
        r_q_neg <= w_sgn & (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
        r_r_neg <= w_sgn & operand_1[DATA_W-1];
      end
    end else begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_waddr  <= '0;
      r_wen    <= 1'b0;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_result    = r_result;
  assign ex_wreg_addr = r_waddr;
  assign ex_wreg_en   = r_wen;
  assign hi_out       = r_hi;
  assign lo_out       = r_lo;

endmodule
